sobel_window_buffer: RTL and testbench

- Upstream neighbour of the Sobel edge-detection stage.
- Accepts a raster-order 8-bit pixel stream, one pixel per handshake, and buffers two full image lines.
- Assembles 3x3 neighbourhoods P0..P8 (row-major: P0 top-left, P8 bottom-right = newest pixel) and launches one gradient computation per interior pixel.
- Holds each window stable until the edge stage reports completion.

---
 rtl/sobel_window_buffer.sv | 223 ++++++++++++++++++++++
 tb/tb_sobel_window_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_buffer.sv
// sobel_window_buffer: keeps two line buffers on a raster 8-bit pixel stream,
// builds 3x3 windows P0..P8 and hands each interior window to the edge stage.
// A window stays frozen until the edge stage signals completion.
// Optional build macro SOBEL_WINDOW_COUNT_EN adds a 16-bit o_window_count
// output that counts starts per frame.
module sobel_window_buffer #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_pixel_valid,
  input  logic [7:0] i_pixel_data,
  output logic       o_pixel_ready,
  output logic       o_gradient_start,
  input  logic       i_gradient_data_ready,
  output logic [7:0] P0,
  output logic [7:0] P1,
  output logic [7:0] P2,
  output logic [7:0] P3,
  output logic [7:0] P4,
  output logic [7:0] P5,
  output logic [7:0] P6,
  output logic [7:0] P7,
  output logic [7:0] P8,
  output logic       o_frame_done
`ifdef SOBEL_WINDOW_COUNT_EN
  ,
  output logic [15:0] o_window_count
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            ready_q, ready_d;
  logic            start_q, start_d;
  logic            frame_done_q, frame_done_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [7:0]      win_q [9];
  logic [7:0]      win_d [9];
  logic [7:0]      lb0_q [IMG_WIDTH];
  logic [7:0]      lb1_q [IMG_WIDTH];

  logic            accept_s;
  logic            last_col_s;
  logic            last_row_s;
  logic            win_done_s;
  logic [7:0]      top_s;
  logic [7:0]      mid_s;

  // Handshake decode and line-buffer read of the column being accepted.
  always_comb begin
    accept_s   = i_pixel_valid & ready_q;
    last_col_s = (col_q == COL_LAST);
    last_row_s = (row_q == ROW_LAST);
    win_done_s = accept_s & (row_q >= ROW_TWO) & (col_q >= COL_TWO);
    top_s      = lb1_q[col_q];
    mid_s      = lb0_q[col_q];
  end

  // Raster position counters, advanced only by an accepted pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept_s) begin
      if (last_col_s) begin
        col_d = {CW{1'b0}};
        if (last_row_s) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_q + ROW_ONE;
        end
      end else begin
        col_d = col_q + COL_ONE;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Window shift: columns move left, the new right column comes from the line buffers.
  always_comb begin
    win_d = win_q;
    if (accept_s) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = top_s;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = mid_s;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = i_pixel_data;
    end else begin
      win_d = win_q;
    end
  end

  // Handshake FSM next state and registered-output values.
  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    start_d      = 1'b0;
    frame_done_d = accept_s & last_col_s & last_row_s;
    case (state_q)
      ST_ACCEPT: begin
        if (win_done_s) begin
          state_d = ST_START;
          start_d = 1'b1;
          ready_d = 1'b0;
        end else begin
          state_d = ST_ACCEPT;
          ready_d = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        ready_d = 1'b0;
      end
      ST_WAIT: begin
        if (i_gradient_data_ready) begin
          state_d = ST_ACCEPT;
          ready_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_ACCEPT;
        ready_d = 1'b1;
      end
    endcase
  end

  // Control, counter and window registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCEPT;
      ready_q      <= 1'b1;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= 8'h00;
      end
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
    end
  end

  // Line buffers age by one line per accept; contents are not reset because rows 0/1 refill them.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb1_q[col_q] <= mid_s;
      lb0_q[col_q] <= i_pixel_data;
    end
  end

`ifdef SOBEL_WINDOW_COUNT_EN
  logic [15:0] count_q, count_d;

  // Per-frame start counter: saturating, cleared while the frame-done pulse is out.
  always_comb begin
    count_d = count_q;
    if (frame_done_q) begin
      count_d = 16'h0000;
    end else if (start_d && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'h0001;
    end else begin
      count_d = count_q;
    end
  end

  // Window counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_window_count = count_q;
`endif

  assign o_pixel_ready    = ready_q;
  assign o_gradient_start = start_q;
  assign o_frame_done     = frame_done_q;
  assign P0 = win_q[0];
  assign P1 = win_q[1];
  assign P2 = win_q[2];
  assign P3 = win_q[3];
  assign P4 = win_q[4];
  assign P5 = win_q[5];
  assign P6 = win_q[6];
  assign P7 = win_q[7];
  assign P8 = win_q[8];

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench for sobel_window_buffer on a 4x4 image with pixel k = k.
module tb_sobel_window_buffer;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 2) * (H - 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       i_pixel_valid;
  logic [7:0] i_pixel_data;
  logic       i_gradient_data_ready;
  logic       o_pixel_ready, o_gradient_start, o_frame_done;
  logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
`ifdef SOBEL_WINDOW_COUNT_EN
  logic [15:0] o_window_count;
`endif

  sobel_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk),
    .rst(rst),
    .i_pixel_valid(i_pixel_valid),
    .i_pixel_data(i_pixel_data),
    .o_pixel_ready(o_pixel_ready),
    .o_gradient_start(o_gradient_start),
    .i_gradient_data_ready(i_gradient_data_ready),
    .P0(P0), .P1(P1), .P2(P2), .P3(P3), .P4(P4),
    .P5(P5), .P6(P6), .P7(P7), .P8(P8),
    .o_frame_done(o_frame_done)
`ifdef SOBEL_WINDOW_COUNT_EN
    ,
    .o_window_count(o_window_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int frames;
    int gap;
    int rdy_delay;
    int exp_starts;
  } vec_t;

  vec_t        vecs [4];
  logic [71:0] exp_win [NWIN];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] cur_win();
    return {P0, P1, P2, P3, P4, P5, P6, P7, P8};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 72'(o_pixel_ready), 72'd1);
    check({tag, "_start"}, 72'(o_gradient_start), 72'd0);
    check({tag, "_frame_done"}, 72'(o_frame_done), 72'd0);
    check({tag, "_window"}, cur_win(), 72'd0);
`ifdef SOBEL_WINDOW_COUNT_EN
    check({tag, "_count"}, 72'(o_window_count), 72'd0);
`endif
  endtask

  // Synchronous reset pulse of one cycle; ends on a falling edge with reset released.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    i_pixel_valid = 1'b0;
    i_gradient_data_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state(tag);
  endtask

  // Push n pixels 0..n-1 back to back from a fresh frame (n <= 11, ready stays high).
  task automatic push_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      i_pixel_valid = 1'b1;
      i_pixel_data  = 8'(i);
      @(negedge clk);
    end
    i_pixel_valid = 1'b0;
  endtask

  // Stream whole frames, answer each start after rdy_delay cycles, check every window.
  task automatic run_stream(input int frames, input int gap, input int rdy_delay, input int exp_starts);
    int k, widx, wait_cnt, cyc;
    bit waiting, rdy_prev, dr_prev;
    bit cnt_clear_chk;
    logic [71:0] held;
    k = 0; widx = 0; wait_cnt = 0; cyc = 0;
    waiting = 1'b0; cnt_clear_chk = 1'b0; held = 72'd0;
    i_pixel_valid = 1'b0;
    i_gradient_data_ready = 1'b0;
    rdy_prev = o_pixel_ready;
    while (!((k == frames * NPIX) && !waiting && o_pixel_ready) && (cyc < 3000)) begin
      dr_prev = i_gradient_data_ready;
      @(negedge clk);
      cyc++;
      if (i_pixel_valid && rdy_prev) k++;
`ifdef SOBEL_WINDOW_COUNT_EN
      if (cnt_clear_chk) begin
        check("count_cleared", 72'(o_window_count), 72'd0);
        cnt_clear_chk = 1'b0;
      end
`endif
      if (waiting) begin
        wait_cnt++;
        check("wait_no_start", 72'(o_gradient_start), 72'd0);
        check("wait_window_held", cur_win(), held);
        check("ready_follows_data_ready", 72'(o_pixel_ready), 72'(dr_prev));
        if (o_pixel_ready) begin
          waiting = 1'b0;
          i_gradient_data_ready = 1'b0;
        end else if (wait_cnt >= rdy_delay) begin
          i_gradient_data_ready = 1'b1;
        end
      end else if (o_gradient_start) begin
        check("start_ready_low", 72'(o_pixel_ready), 72'd0);
        check("window", cur_win(), exp_win[widx % NWIN]);
        check("frame_done_with_start", 72'(o_frame_done), 72'((widx % NWIN) == (NWIN - 1)));
`ifdef SOBEL_WINDOW_COUNT_EN
        if (o_frame_done) begin
          check("count_at_frame_end", 72'(o_window_count), 72'(NWIN));
          cnt_clear_chk = 1'b1;
        end
`endif
        widx++;
        waiting = 1'b1;
        wait_cnt = 0;
        held = cur_win();
      end else begin
        check("frame_done_idle", 72'(o_frame_done), 72'd0);
      end
      rdy_prev = o_pixel_ready;
      if (k < frames * NPIX) begin
        i_pixel_valid = (gap != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
        i_pixel_data  = 8'(k % NPIX);
      end else begin
        i_pixel_valid = 1'b0;
      end
    end
    check("stream_in_budget", 72'(cyc < 3000), 72'd1);
    check("start_count", 72'(widx), 72'(exp_starts));
    check("pixel_count", 72'(k), 72'(frames * NPIX));
    i_pixel_valid = 1'b0;
    i_gradient_data_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_pixel_valid = 1'b0;
    i_pixel_data = 8'h00;
    i_gradient_data_ready = 1'b0;

    exp_win[0] = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    exp_win[1] = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    exp_win[2] = {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14};
    exp_win[3] = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};

    vecs[0] = '{frames: 1, gap: 0, rdy_delay: 3,  exp_starts: NWIN};
    vecs[1] = '{frames: 2, gap: 1, rdy_delay: 3,  exp_starts: 2 * NWIN};
    vecs[2] = '{frames: 1, gap: 0, rdy_delay: 12, exp_starts: NWIN};
    vecs[3] = '{frames: 1, gap: 1, rdy_delay: 1,  exp_starts: NWIN};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("por");

    // data_ready while accepting must be ignored
    i_gradient_data_ready = 1'b1;
    @(negedge clk);
    i_gradient_data_ready = 1'b0;
    check("idle_dr_ready", 72'(o_pixel_ready), 72'd1);
    check("idle_dr_start", 72'(o_gradient_start), 72'd0);
    @(negedge clk);
    check("idle_dr_ready2", 72'(o_pixel_ready), 72'd1);
    check("idle_dr_window", cur_win(), 72'd0);

    for (int v = 0; v < 4; v++) begin
      apply_reset("vec_rst");
      run_stream(vecs[v].frames, vecs[v].gap, vecs[v].rdy_delay, vecs[v].exp_starts);
    end

    // reset after pixel 7, then a full clean frame
    apply_reset("pre_mid");
    push_pixels(8);
    check("mid_no_start", 72'(o_gradient_start), 72'd0);
    apply_reset("mid_frame");
    run_stream(1, 0, 3, NWIN);

    // reset while a window is pending, then a full clean frame
    apply_reset("pre_wait");
    push_pixels(11);
    check("pending_start", 72'(o_gradient_start), 72'd1);
    check("pending_window", cur_win(), exp_win[0]);
    apply_reset("mid_wait");
    @(negedge clk);
    check("after_wait_rst_start", 72'(o_gradient_start), 72'd0);
    check("after_wait_rst_ready", 72'(o_pixel_ready), 72'd1);
    run_stream(1, 0, 3, NWIN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
